// File: rtl/gpio_player_sync.sv
// Second-player control conditioner: synchronise, debounce and
// frame-latch two raw button lines, with one-cycle press pulses.
module gpio_player_sync #(
  parameter int DEBOUNCE_CYCLES = 40000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic gpio_left,
  input  logic gpio_right,
  input  logic v_tick,
  output logic m_left,
  output logic m_right,
  output logic left_press,
  output logic right_press
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Bit 0 is the left channel, bit 1 the right channel.
  logic [1:0] raw;
  logic [1:0] s1_q, s1_d;
  logic [1:0] s2_q, s2_d;
  logic [1:0] deb_q, deb_d;
  logic [1:0] m_q, m_d;
  logic [1:0] press_q, press_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic v_q, v_d;
  logic v_rise;

  assign raw = {gpio_right, gpio_left};

  always_comb begin
    s1_d    = raw;
    s2_d    = s1_q;
    v_d     = v_tick;
    v_rise  = v_tick & ~v_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    press_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    // Latch takes the pre-update debounced level.
    if (v_rise) begin
      m_d     = deb_q;
      press_d = deb_q & ~m_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
      m_q     <= '0;
      press_q <= '0;
      v_q     <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      press_q <= press_d;
      v_q     <= v_d;
    end
  end

  assign m_left      = m_q[0];
  assign m_right     = m_q[1];
  assign left_press  = press_q[0];
  assign right_press = press_q[1];

endmodule

// File: tb/tb_gpio_player_sync.sv
// Directed bench for gpio_player_sync with a short debounce window
// and hand-placed vsync edges.
module tb_gpio_player_sync;

  localparam int DEB = 8;

  logic clk = 1'b0;
  logic rst;
  logic gpio_left;
  logic gpio_right;
  logic v_tick;
  logic m_left;
  logic m_right;
  logic left_press;
  logic right_press;

  int checks = 0;
  int failures = 0;
  int lp_cnt, rp_cnt, ml_cnt, mr_cnt;
  logic ml_a, mr_a, lp_a, rp_a, lp_b, rp_b;

  gpio_player_sync #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gpio_left(gpio_left),
    .gpio_right(gpio_right),
    .v_tick(v_tick),
    .m_left(m_left),
    .m_right(m_right),
    .left_press(left_press),
    .right_press(right_press)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    lp_cnt += (left_press === 1'b1) ? 1 : 0;
    rp_cnt += (right_press === 1'b1) ? 1 : 0;
    ml_cnt += (m_left === 1'b1) ? 1 : 0;
    mr_cnt += (m_right === 1'b1) ? 1 : 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic clr();
    lp_cnt = 0;
    rp_cnt = 0;
    ml_cnt = 0;
    mr_cnt = 0;
  endtask

  // Rising v_tick seen on the next edge; v_tick held 4 cycles.
  task automatic vs_rise();
    v_tick = 1'b1;
    step();
    ml_a = m_left;
    mr_a = m_right;
    lp_a = left_press;
    rp_a = right_press;
    step();
    lp_b = left_press;
    rp_b = right_press;
    idle(2);
    v_tick = 1'b0;
  endtask

  task automatic frame();
    vs_rise();
    idle(96);
  endtask

  task automatic apply_rst();
    rst = 1'b1;
    gpio_left = 1'b0;
    gpio_right = 1'b0;
    v_tick = 1'b0;
    idle(2);
    rst = 1'b0;
    clr();
  endtask

  task automatic test_reset();
    logic [3:0] o;
    rst = 1'b1;
    gpio_left = 1'b1;
    gpio_right = 1'b1;
    v_tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      o = {m_left, m_right, left_press, right_press};
      checks++;
      if (o !== 4'b0) begin
        failures++;
        $display("FAIL reset_hold cyc%0d got=%b exp=0000", i, o);
      end
    end
    rst = 1'b0;
    step();
    o = {m_left, m_right, left_press, right_press};
    checks++;
    if (o !== 4'b0) begin
      failures++;
      $display("FAIL reset_after got=%b exp=0000", o);
    end
  endtask

  task automatic test_clean_press();
    apply_rst();
    idle(9);
    gpio_left = 1'b1;
    idle(20);
    checks++;
    if (ml_cnt !== 0) begin
      failures++;
      $display("FAIL press_pre_vsync m_left_cycles=%0d exp=0", ml_cnt);
    end
    clr();
    vs_rise();
    idle(96);
    checks++;
    if ({ml_a, lp_a, lp_b, mr_a} !== 4'b1100) begin
      failures++;
      $display("FAIL press_latch got m/p/p+1/mr=%b exp=1100",
               {ml_a, lp_a, lp_b, mr_a});
    end
    checks++;
    if (lp_cnt !== 1 || rp_cnt !== 0 || mr_cnt !== 0) begin
      failures++;
      $display("FAIL press_once lp=%0d rp=%0d mr=%0d exp=1 0 0",
               lp_cnt, rp_cnt, mr_cnt);
    end
    gpio_left = 1'b0;
    idle(30);
    checks++;
    if (m_left !== 1'b1) begin
      failures++;
      $display("FAIL press_hold m_left=%b exp=1", m_left);
    end
    vs_rise();
    checks++;
    if ({ml_a, lp_a} !== 2'b00) begin
      failures++;
      $display("FAIL release_latch got m/p=%b exp=00", {ml_a, lp_a});
    end
  endtask

  task automatic test_latency_edge();
    apply_rst();
    gpio_left = 1'b1;
    idle(9);
    vs_rise();
    checks++;
    if (ml_a !== 1'b0) begin
      failures++;
      $display("FAIL latch_same_edge m_left=%b exp=0", ml_a);
    end
    idle(5);
    vs_rise();
    checks++;
    if ({ml_a, lp_a} !== 2'b11) begin
      failures++;
      $display("FAIL latch_next_frame m/p=%b exp=11", {ml_a, lp_a});
    end
    apply_rst();
    gpio_left = 1'b1;
    idle(10);
    vs_rise();
    checks++;
    if ({ml_a, lp_a} !== 2'b11) begin
      failures++;
      $display("FAIL latch_first_edge m/p=%b exp=11", {ml_a, lp_a});
    end
  endtask

  task automatic test_min_width();
    apply_rst();
    gpio_left = 1'b1;
    idle(DEB);
    gpio_left = 1'b0;
    idle(3);
    vs_rise();
    checks++;
    if ({ml_a, lp_a} !== 2'b11) begin
      failures++;
      $display("FAIL width_accept m/p=%b exp=11", {ml_a, lp_a});
    end
    apply_rst();
    gpio_left = 1'b1;
    idle(DEB - 1);
    gpio_left = 1'b0;
    idle(3);
    frame();
    frame();
    checks++;
    if (ml_cnt !== 0 || lp_cnt !== 0) begin
      failures++;
      $display("FAIL width_reject m=%0d p=%0d exp=0 0", ml_cnt, lp_cnt);
    end
  endtask

  task automatic test_glitch();
    apply_rst();
    gpio_right = 1'b1;
    idle(5);
    gpio_right = 1'b0;
    idle(2);
    gpio_right = 1'b1;
    idle(5);
    gpio_right = 1'b0;
    frame();
    frame();
    frame();
    checks++;
    if (mr_cnt !== 0 || rp_cnt !== 0) begin
      failures++;
      $display("FAIL glitch m_right=%0d press=%0d exp=0 0",
               mr_cnt, rp_cnt);
    end
  endtask

  task automatic test_frame_gating();
    apply_rst();
    vs_rise();
    idle(10);
    gpio_left = 1'b1;
    idle(20);
    gpio_left = 1'b0;
    idle(20);
    idle(40);
    vs_rise();
    idle(10);
    checks++;
    if (ml_cnt !== 0 || lp_cnt !== 0) begin
      failures++;
      $display("FAIL gating m_left=%0d press=%0d exp=0 0",
               ml_cnt, lp_cnt);
    end
  endtask

  task automatic test_simultaneous();
    apply_rst();
    gpio_left = 1'b1;
    gpio_right = 1'b1;
    idle(15);
    vs_rise();
    checks++;
    if ({ml_a, mr_a, lp_a, rp_a} !== 4'b1111) begin
      failures++;
      $display("FAIL simul_rise got=%b exp=1111",
               {ml_a, mr_a, lp_a, rp_a});
    end
    checks++;
    if ({lp_b, rp_b} !== 2'b00) begin
      failures++;
      $display("FAIL simul_pulse_end got=%b exp=00", {lp_b, rp_b});
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [3:0] o;
    apply_rst();
    gpio_left = 1'b1;
    idle(7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    o = {m_left, m_right, left_press, right_press};
    checks++;
    if (o !== 4'b0) begin
      failures++;
      $display("FAIL midrst_clear got=%b exp=0000", o);
    end
    idle(8);
    vs_rise();
    checks++;
    if (ml_a !== 1'b0) begin
      failures++;
      $display("FAIL midrst_early m_left=%b exp=0", ml_a);
    end
    idle(8);
    vs_rise();
    checks++;
    if ({ml_a, lp_a, lp_b} !== 3'b110) begin
      failures++;
      $display("FAIL midrst_accept m/p/p+1=%b exp=110",
               {ml_a, lp_a, lp_b});
    end
  endtask

  initial begin
    rst = 1'b1;
    gpio_left = 1'b0;
    gpio_right = 1'b0;
    v_tick = 1'b0;
    clr();
    test_reset();
    test_clean_press();
    test_latency_edge();
    test_min_width();
    test_glitch();
    test_frame_gating();
    test_simultaneous();
    test_reset_mid_debounce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
